// File: rtl/frogger_gfx_pkg.sv
// Shared graphics types for the object compositor: the object-table entry and the colour palette.
// Coordinates are stored zero-extended to OBJ_COORD_W bits, so any COORD_W up to 16 fits.
package frogger_gfx_pkg;

  localparam int OBJ_COORD_W = 16;

  typedef struct packed {
    logic [OBJ_COORD_W-1:0] x;
    logic [OBJ_COORD_W-1:0] y;
    logic [OBJ_COORD_W-1:0] w;
    logic [OBJ_COORD_W-1:0] h;
    logic [2:0]             cls;
    logic                   en;
  } obj_t;

  localparam logic [23:0] CLASS_RGB [0:7] = '{
    24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
    24'hFF00FF, 24'h00FFFF, 24'hFFFFFF, 24'h808080
  };

  localparam logic [23:0] BG_RGB    = 24'h000040;
  localparam logic [23:0] FLASH_RGB = 24'hF0F0F0;

endpackage

// File: rtl/obj_hit_test.sv
// Combinational coverage test of one object slot against a pixel, with horizontal screen wrap.
// Zero latency, no flow control; the result is registered by the caller.
module obj_hit_test
  import frogger_gfx_pkg::*;
#(
  parameter int COORD_W  = 11,
  parameter int SCREEN_W = 640
) (
  input  obj_t               obj,
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  output logic               hit
);

  // One bit wider than the stored fields so x+w and y+h never wrap.
  localparam int SW = OBJ_COORD_W + 1;
  localparam logic [SW-1:0] SCREEN = SW'(SCREEN_W);

  logic [SW-1:0] dx, dy, x_lo, y_lo, x_end, y_end, wrap_end;
  logic          in_x, in_y;

  always_comb begin
    dx       = SW'(draw_x);
    dy       = SW'(draw_y);
    x_lo     = {1'b0, obj.x};
    y_lo     = {1'b0, obj.y};
    x_end    = {1'b0, obj.x} + {1'b0, obj.w};
    y_end    = {1'b0, obj.y} + {1'b0, obj.h};
    wrap_end = x_end - SCREEN;
    in_x     = ((dx >= x_lo) && (dx < x_end)) ||
               ((x_end > SCREEN) && (dx < wrap_end));
    in_y     = (dy >= y_lo) && (dy < y_end);
    hit      = obj.en && in_x && in_y;
  end

endmodule

// File: rtl/object_compositor.sv
// Sprite compositor: double-buffered object table, per-slot hit test, priority pick, palette lookup.
// 2-cycle latency pix_valid -> rgb_valid, one pixel per clock, no backpressure.
module object_compositor
  import frogger_gfx_pkg::*;
#(
  parameter int NUM_OBJ      = 8,
  parameter int COORD_W      = 11,
  parameter int SCREEN_W     = 640,
  parameter int FLASH_FRAMES = 8,
  localparam int IDX_W       = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               frame_start,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               obj_we,
  input  logic [IDX_W-1:0]   obj_idx,
  input  logic [COORD_W-1:0] obj_x,
  input  logic [COORD_W-1:0] obj_y,
  input  logic [COORD_W-1:0] obj_w,
  input  logic [COORD_W-1:0] obj_h,
  input  logic [2:0]         obj_class,
  input  logic               obj_en,
  input  logic               hit_flash,
  output logic [7:0]         Red,
  output logic [7:0]         Green,
  output logic [7:0]         Blue,
  output logic               rgb_valid,
  output logic               hit_obj_valid,
  output logic [IDX_W-1:0]   hit_obj_idx
);

  localparam int FL_W = $clog2(FLASH_FRAMES + 1);
  localparam logic [IDX_W:0]   IDX_LIM  = (IDX_W + 1)'(NUM_OBJ);
  localparam logic [COORD_W:0] SCREEN_L = (COORD_W + 1)'(SCREEN_W);
  localparam logic [FL_W-1:0]  FLASH_LD = FL_W'(FLASH_FRAMES);

  obj_t shadow     [NUM_OBJ];
  obj_t active     [NUM_OBJ];
  obj_t shadow_nxt [NUM_OBJ];
  logic wr_ok;

  assign wr_ok = obj_we && ({1'b0, obj_idx} < IDX_LIM) &&
                 ({1'b0, obj_x} < SCREEN_L) && (obj_w != '0);

  // The commit takes the post-write shadow so a write alongside frame_start lands this frame.
  always_comb begin
    shadow_nxt = shadow;
    if (wr_ok) begin
      shadow_nxt[obj_idx] = '{x:   OBJ_COORD_W'(obj_x),
                              y:   OBJ_COORD_W'(obj_y),
                              w:   OBJ_COORD_W'(obj_w),
                              h:   OBJ_COORD_W'(obj_h),
                              cls: obj_class,
                              en:  obj_en};
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < NUM_OBJ; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      shadow <= shadow_nxt;
      if (frame_start) active <= shadow_nxt;
    end
  end

  logic [FL_W-1:0] flash_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)                                flash_cnt <= '0;
    else if (hit_flash)                       flash_cnt <= FLASH_LD;
    else if (frame_start && flash_cnt != '0)  flash_cnt <= flash_cnt - 1'b1;
  end

  logic [NUM_OBJ-1:0] hit_vec;

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_hit
    obj_hit_test #(
      .COORD_W  (COORD_W),
      .SCREEN_W (SCREEN_W)
    ) u_hit (
      .obj    (active[g]),
      .draw_x (DrawX),
      .draw_y (DrawY),
      .hit    (hit_vec[g])
    );
  end

  // Stage 1: hit vector plus each slot's class, so a mid-pixel commit cannot skew the colour.
  logic               s1_vld;
  logic [NUM_OBJ-1:0] s1_hit;
  logic [2:0]         s1_cls [NUM_OBJ];

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_vld <= 1'b0;
      s1_hit <= '0;
      for (int i = 0; i < NUM_OBJ; i++) s1_cls[i] <= '0;
    end else begin
      s1_vld <= pix_valid;
      s1_hit <= hit_vec;
      for (int i = 0; i < NUM_OBJ; i++) s1_cls[i] <= active[i].cls;
    end
  end

  logic             win_vld;
  logic [IDX_W-1:0] win_idx;
  logic [2:0]       win_cls;
  logic [23:0]      pix_rgb;

  // Descending scan so the lowest covering slot is the last to overwrite.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_cls = '0;
    for (int i = NUM_OBJ - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(i);
        win_cls = s1_cls[i];
      end
    end
    if (win_vld)           pix_rgb = CLASS_RGB[win_cls];
    else if (flash_cnt[0]) pix_rgb = FLASH_RGB;
    else                   pix_rgb = BG_RGB;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_valid     <= 1'b0;
      Red           <= '0;
      Green         <= '0;
      Blue          <= '0;
      hit_obj_valid <= 1'b0;
      hit_obj_idx   <= '0;
    end else begin
      rgb_valid <= s1_vld;
      if (s1_vld) begin
        {Red, Green, Blue} <= pix_rgb;
        hit_obj_valid      <= win_vld;
        hit_obj_idx        <= win_idx;
      end
    end
  end

endmodule

// File: tb/tb_object_compositor.sv
// Directed bench for object_compositor: priority, wrap, commit, drop, streaming, flash, reset.
module tb_object_compositor;
  import frogger_gfx_pkg::*;

  logic        Clk, Reset, frame_start, pix_valid;
  logic [10:0] DrawX, DrawY;
  logic        obj_we;
  logic [2:0]  obj_idx;
  logic [10:0] obj_x, obj_y, obj_w, obj_h;
  logic [2:0]  obj_class;
  logic        obj_en, hit_flash;
  logic [7:0]  Red, Green, Blue;
  logic        rgb_valid, hit_obj_valid;
  logic [2:0]  hit_obj_idx;

  int checks = 0;
  int errors = 0;

  object_compositor dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .pix_valid(pix_valid),
    .DrawX(DrawX), .DrawY(DrawY), .obj_we(obj_we), .obj_idx(obj_idx),
    .obj_x(obj_x), .obj_y(obj_y), .obj_w(obj_w), .obj_h(obj_h),
    .obj_class(obj_class), .obj_en(obj_en), .hit_flash(hit_flash),
    .Red(Red), .Green(Green), .Blue(Blue), .rgb_valid(rgb_valid),
    .hit_obj_valid(hit_obj_valid), .hit_obj_idx(hit_obj_idx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_obj(input int idx, input int x, input int y, input int w, input int h,
                           input int cls, input logic en, input logic with_frame);
    obj_we = 1'b1; obj_idx = 3'(idx);
    obj_x = 11'(x); obj_y = 11'(y); obj_w = 11'(w); obj_h = 11'(h);
    obj_class = 3'(cls); obj_en = en; frame_start = with_frame;
    tick();
    obj_we = 1'b0; frame_start = 1'b0;
  endtask

  task automatic new_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Result packing: {rgb_valid one cycle after, rgb_valid two cycles after, hit_valid, idx, rgb}
  task automatic pixel(input int x, input int y, output logic [29:0] res);
    logic early;
    DrawX = 11'(x); DrawY = 11'(y); pix_valid = 1'b1;
    tick();
    pix_valid = 1'b0;
    early = rgb_valid;
    tick();
    res = {early, rgb_valid, hit_obj_valid, hit_obj_idx, Red, Green, Blue};
  endtask

  function automatic logic [29:0] px(input logic hv, input int idx, input logic [23:0] rgb);
    logic [2:0] i3;
    i3 = 3'(idx);
    return {1'b0, 1'b1, hv, i3, rgb};
  endfunction

  task automatic test_reset();
    logic [29:0] r;
    Reset = 1'b1;
    tick(); tick();
    checks++;
    if ({Red, Green, Blue, rgb_valid, hit_obj_valid, hit_obj_idx} !== 29'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0",
               {Red, Green, Blue, rgb_valid, hit_obj_valid, hit_obj_idx});
    end
    Reset = 1'b0;
    tick();
    pixel(0, 0, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL reset_bg_pixel got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
  endtask

  task automatic test_priority();
    logic [29:0] r;
    write_obj(0, 100, 200, 80, 40, 2, 1'b1, 1'b0);
    write_obj(3, 100, 200, 80, 40, 5, 1'b1, 1'b0);
    new_frame();
    pixel(120, 210, r);
    checks++;
    if (r !== px(1'b1, 0, CLASS_RGB[2])) begin
      errors++; $display("FAIL prio_overlap got %h want %h", r, px(1'b1, 0, CLASS_RGB[2]));
    end
    pixel(179, 239, r);
    checks++;
    if (r !== px(1'b1, 0, CLASS_RGB[2])) begin
      errors++; $display("FAIL prio_last_pixel got %h want %h", r, px(1'b1, 0, CLASS_RGB[2]));
    end
    pixel(180, 210, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL prio_x_end got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
    pixel(120, 240, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL prio_y_end got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
    write_obj(0, 100, 200, 80, 40, 2, 1'b0, 1'b1);
    pixel(120, 210, r);
    checks++;
    if (r !== px(1'b1, 3, CLASS_RGB[5])) begin
      errors++; $display("FAIL prio_disabled_slot got %h want %h", r, px(1'b1, 3, CLASS_RGB[5]));
    end
    write_obj(0, 100, 200, 80, 40, 2, 1'b1, 1'b1);
  endtask

  task automatic test_wrap();
    logic [29:0] r;
    write_obj(1, 600, 0, 80, 480, 4, 1'b1, 1'b0);
    new_frame();
    pixel(620, 300, r);
    checks++;
    if (r !== px(1'b1, 1, CLASS_RGB[4])) begin
      errors++; $display("FAIL wrap_620 got %h want %h", r, px(1'b1, 1, CLASS_RGB[4]));
    end
    pixel(30, 300, r);
    checks++;
    if (r !== px(1'b1, 1, CLASS_RGB[4])) begin
      errors++; $display("FAIL wrap_30 got %h want %h", r, px(1'b1, 1, CLASS_RGB[4]));
    end
    pixel(39, 300, r);
    checks++;
    if (r !== px(1'b1, 1, CLASS_RGB[4])) begin
      errors++; $display("FAIL wrap_39 got %h want %h", r, px(1'b1, 1, CLASS_RGB[4]));
    end
    pixel(40, 300, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL wrap_40 got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
    pixel(599, 300, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL wrap_599 got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
  endtask

  task automatic test_commit();
    logic [29:0] r;
    write_obj(2, 300, 100, 10, 10, 1, 1'b1, 1'b0);
    pixel(305, 105, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL commit_before_frame got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
    new_frame();
    pixel(305, 105, r);
    checks++;
    if (r !== px(1'b1, 2, CLASS_RGB[1])) begin
      errors++; $display("FAIL commit_after_frame got %h want %h", r, px(1'b1, 2, CLASS_RGB[1]));
    end
    write_obj(2, 300, 100, 10, 10, 3, 1'b1, 1'b1);
    pixel(305, 105, r);
    checks++;
    if (r !== px(1'b1, 2, CLASS_RGB[3])) begin
      errors++; $display("FAIL commit_coincident got %h want %h", r, px(1'b1, 2, CLASS_RGB[3]));
    end
  endtask

  task automatic test_drop();
    logic [29:0] r;
    write_obj(2, 640, 100, 10, 10, 6, 1'b1, 1'b0);
    new_frame();
    pixel(305, 105, r);
    checks++;
    if (r !== px(1'b1, 2, CLASS_RGB[3])) begin
      errors++; $display("FAIL drop_x640 got %h want %h", r, px(1'b1, 2, CLASS_RGB[3]));
    end
    write_obj(2, 300, 100, 0, 10, 6, 1'b1, 1'b1);
    pixel(305, 105, r);
    checks++;
    if (r !== px(1'b1, 2, CLASS_RGB[3])) begin
      errors++; $display("FAIL drop_w0 got %h want %h", r, px(1'b1, 2, CLASS_RGB[3]));
    end
  endtask

  task automatic test_back_to_back();
    int          bx [4] = '{120, 620, 500, 305};
    int          by [4] = '{210, 300, 400, 105};
    logic [29:0] be [4];
    logic [29:0] e;
    be[0] = px(1'b1, 0, CLASS_RGB[2]);
    be[1] = px(1'b1, 1, CLASS_RGB[4]);
    be[2] = px(1'b0, 0, BG_RGB);
    be[3] = px(1'b1, 2, CLASS_RGB[3]);
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        DrawX = 11'(bx[i]); DrawY = 11'(by[i]); pix_valid = 1'b1;
      end else begin
        pix_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        e = be[i-1];
        checks++;
        if ({rgb_valid, hit_obj_valid, hit_obj_idx, Red, Green, Blue} !== e[28:0]) begin
          errors++;
          $display("FAIL b2b_pixel%0d got %h want %h", i - 1,
                   {rgb_valid, hit_obj_valid, hit_obj_idx, Red, Green, Blue}, e[28:0]);
        end
      end
    end
    tick();
    checks++;
    if (rgb_valid !== 1'b0 || {Red, Green, Blue} !== CLASS_RGB[3]) begin
      errors++;
      $display("FAIL b2b_hold got vld=%b rgb=%h want vld=0 rgb=%h",
               rgb_valid, {Red, Green, Blue}, CLASS_RGB[3]);
    end
  endtask

  task automatic test_flash();
    logic [29:0] r;
    logic [23:0] bg;
    hit_flash = 1'b1;
    tick();
    hit_flash = 1'b0;
    pixel(500, 400, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL flash_cnt8 got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
    for (int k = 1; k <= 8; k++) begin
      new_frame();
      bg = (((8 - k) % 2) == 1) ? FLASH_RGB : BG_RGB;
      pixel(500, 400, r);
      checks++;
      if (r !== px(1'b0, 0, bg)) begin
        errors++; $display("FAIL flash_frame%0d got %h want %h", k, r, px(1'b0, 0, bg));
      end
      if (k == 1) begin
        pixel(120, 210, r);
        checks++;
        if (r !== px(1'b1, 0, CLASS_RGB[2])) begin
          errors++; $display("FAIL flash_obj_unaffected got %h want %h", r, px(1'b1, 0, CLASS_RGB[2]));
        end
      end
    end
    new_frame();
    pixel(500, 400, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL flash_stays_zero got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
    hit_flash = 1'b1; frame_start = 1'b1;
    tick();
    hit_flash = 1'b0; frame_start = 1'b0;
    pixel(500, 400, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL flash_load_wins got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
    new_frame();
    pixel(500, 400, r);
    checks++;
    if (r !== px(1'b0, 0, FLASH_RGB)) begin
      errors++; $display("FAIL flash_reload_7 got %h want %h", r, px(1'b0, 0, FLASH_RGB));
    end
  endtask

  task automatic test_reset_mid();
    logic [29:0] r;
    DrawX = 11'd120; DrawY = 11'd210; pix_valid = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (rgb_valid !== 1'b1 || {Red, Green, Blue} !== CLASS_RGB[2]) begin
      errors++;
      $display("FAIL rstmid_stream got vld=%b rgb=%h want vld=1 rgb=%h",
               rgb_valid, {Red, Green, Blue}, CLASS_RGB[2]);
    end
    #2 Reset = 1'b1;
    #1;
    checks++;
    if ({Red, Green, Blue, rgb_valid, hit_obj_valid, hit_obj_idx} !== 29'd0) begin
      errors++;
      $display("FAIL rstmid_async got %h want 0",
               {Red, Green, Blue, rgb_valid, hit_obj_valid, hit_obj_idx});
    end
    tick(); tick();
    pix_valid = 1'b0;
    Reset = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({rgb_valid, Red, Green, Blue} !== 25'd0) begin
      errors++;
      $display("FAIL rstmid_no_valid got %h want 0", {rgb_valid, Red, Green, Blue});
    end
    pixel(120, 210, r);
    checks++;
    if (r !== px(1'b0, 0, BG_RGB)) begin
      errors++; $display("FAIL rstmid_first_pixel got %h want %h", r, px(1'b0, 0, BG_RGB));
    end
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; DrawX = '0; DrawY = '0;
    obj_we = 1'b0; obj_idx = '0; obj_x = '0; obj_y = '0; obj_w = '0; obj_h = '0;
    obj_class = '0; obj_en = 1'b0; hit_flash = 1'b0;
    test_reset();
    test_priority();
    test_wrap();
    test_commit();
    test_drop();
    test_back_to_back();
    test_flash();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/object_compositor.md
OBJECT_COMPOSITOR -- requirements
Module: object_compositor

Interface
REQ-001 SHALL have parameter NUM_OBJ, default 8: number of object slots, 1..16.
REQ-002 SHALL have parameter COORD_W, default 11: coordinate width.
REQ-003 SHALL have parameter SCREEN_W, default 640: horizontal wrap modulus.
REQ-004 SHALL have parameter FLASH_FRAMES, default 8: collision-flash length in frames.
REQ-005 SHALL have port Clk, input, 1: sole clock; one clock, all logic on rising edge.
REQ-006 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port frame_start, input, 1: one-cycle pulse at start of each frame.
REQ-008 SHALL have port pix_valid, input, 1: DrawX/DrawY valid this cycle.
REQ-009 SHALL have ports DrawX and DrawY, input, COORD_W each: pixel coordinate.
REQ-010 SHALL have ports obj_we (1), obj_idx ($clog2(NUM_OBJ)), obj_x/obj_y/obj_w/obj_h (COORD_W each), obj_class (3) and obj_en (1), all inputs: object-table write port.
REQ-011 SHALL have port hit_flash, input, 1: one-cycle collision pulse.
REQ-012 SHALL have ports Red, Green and Blue, output, 8 each: pixel colour.
REQ-013 SHALL have port rgb_valid, output, 1: Red/Green/Blue valid.
REQ-014 SHALL have ports hit_obj_valid (1) and hit_obj_idx ($clog2(NUM_OBJ)), outputs: which object produced the pixel.

Function
REQ-015 SHALL keep two object tables, shadow and active; obj_we writes shadow[obj_idx] only.
REQ-016 SHALL drop a write with obj_x >= SCREEN_W, obj_w == 0 or obj_idx >= NUM_OBJ; shadow stays unchanged.
REQ-017 SHALL copy shadow to active on frame_start; a write in the same cycle is included in the copy (write-then-commit).
REQ-018 SHALL test coverage only against active: x-hit when x <= DrawX < x+w; if x+w > SCREEN_W, also when DrawX < x+w-SCREEN_W (wrap); y-hit when y <= DrawY < y+h.
REQ-019 SHALL compute all edge sums at COORD_W+1 bits; no overflow truncation.
REQ-020 SHALL treat an object as covering only when obj_en=1 for that slot.
REQ-021 SHALL select the lowest covering index on overlap (index 0 is highest priority).
REQ-022 SHALL be a 2-stage pipeline: stage 1 registers per-slot hit vector and DrawX/DrawY; stage 2 registers priority result and palette colour.
REQ-023 SHALL assert rgb_valid exactly 2 cycles after pix_valid; back-to-back pixels at full rate.
REQ-024 SHALL output CLASS_RGB[class] of the winner, with hit_obj_valid=1 and hit_obj_idx=winner.
REQ-025 SHALL output, when no object covers: hit_obj_valid=0, hit_obj_idx=0, colour BG_RGB, or FLASH_RGB when flash_cnt is odd.
REQ-026 SHALL have a flash counter that loads FLASH_FRAMES on hit_flash and decrements by 1 on each frame_start while nonzero; when hit_flash and frame_start coincide, the load wins.
REQ-027 SHALL hold Red/Green/Blue at their last values while rgb_valid=0.

Reset
REQ-028 SHALL on Reset clear all shadow and active slots (enable=0, fields 0), flash_cnt=0, pipeline valids=0, Red=Green=Blue=0, hit_obj_valid=0 and hit_obj_idx=0.
REQ-029 SHALL discard in-flight pixels when Reset is asserted mid-frame; the first rgb_valid comes 2 cycles after the first post-reset pix_valid.

Structure
REQ-030 SHALL place the obj_t struct (x, y, w, h, class, en), CLASS_RGB[0:7], BG_RGB and FLASH_RGB in shared package frogger_gfx_pkg.
REQ-031 SHALL implement per-slot coverage as one sub-module, obj_hit_test, instantiated NUM_OBJ times by generate.

Verification
REQ-032 SHALL verify overlap priority: slots 0 and 3 at (100,200,80,40); commit; pixel (120,210) -> slot-0 class colour, hit_obj_idx=0, rgb_valid 2 cycles later.
REQ-033 SHALL verify wrap: slot 1 at x=600, w=80; pixels DrawX=620 and 30 -> hit, DrawX=40 -> BG_RGB.
REQ-034 SHALL verify shadow commit: write slot 2 mid-frame -> no effect until frame_start; write coincident with frame_start -> visible next frame.
REQ-035 SHALL verify flash: hit_flash, then 8 frame_starts -> background FLASH_RGB on odd counts (7,5,3,1), BG_RGB after; hit_flash with frame_start -> counter=8.
REQ-036 SHALL verify dropped writes: obj_x=640 or obj_w=0 -> slot unchanged.
REQ-037 SHALL verify reset mid-stream: Reset during continuous pix_valid -> outputs 0, no rgb_valid until 2 cycles after the next pix_valid.
